line_centroid_accum: RTL and testbench

Upstream producer for the centroid flag delay stage. Accumulates one sensor line of pixel samples into a weighted index sum (numerator) and an intensity sum (denominator) for the external divider. At end of line it emits a one-cycle centroid_flag_o pulse. The downstream delay stage realigns that pulse with the divider result before the FIFO write.

---
 rtl/line_centroid_accum.sv | 256 +++++++++++++++++++++++++
 tb/tb_line_centroid_accum.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_centroid_accum.sv
// line_centroid_accum
//   Accumulates one sensor line of thresholded pixel samples into a weighted
//   index sum (numerator) and an intensity sum (denominator) for an external
//   divider. At end of line it publishes the sums and emits a one-cycle
//   centroid_flag_o pulse that a downstream delay stage realigns with the
//   divider result.
//
// Ports
//   clk_200MHz_i     system clock, all logic on the rising edge
//   rst_n_i          synchronous active-low reset
//   line_start_i     one-cycle pulse; the next accepted pixel is index 0
//   line_end_i       one-cycle pulse; closes the line (same-cycle pixel kept)
//   pix_valid_i      pixel strobe
//   pix_data_i       pixel intensity
//   threshold_i      background threshold, captured on line_start_i
//   numer_o          sum of idx*w over the line (0 when rejected)
//   denom_o          sum of w over the line (0 when rejected)
//   hits_o           number of pixels with w > 0
//   line_valid_o     spot accepted
//   ovf_err_o        line carried more than 2**IDX_W pixels
//   centroid_flag_o  one-cycle result strobe
module line_centroid_accum #(
  parameter int PIX_W   = 12,
  parameter int IDX_W   = 11,
  parameter int DEN_W   = 23,
  parameter int NUM_W   = 34,
  parameter int MIN_PIX = 3
) (
  input  logic             clk_200MHz_i,
  input  logic             rst_n_i,
  input  logic             line_start_i,
  input  logic             line_end_i,
  input  logic             pix_valid_i,
  input  logic [PIX_W-1:0] pix_data_i,
  input  logic [PIX_W-1:0] threshold_i,
  output logic [NUM_W-1:0] numer_o,
  output logic [DEN_W-1:0] denom_o,
  output logic [IDX_W:0]   hits_o,
  output logic             line_valid_o,
  output logic             ovf_err_o,
  output logic             centroid_flag_o
);

  localparam int PROD_W = PIX_W + IDX_W;
  localparam logic [IDX_W:0] MIN_HITS = (IDX_W+1)'(MIN_PIX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   drain_cnt_q, drain_cnt_d;

  logic [PIX_W-1:0] thr_q, thr_d;
  // idx counts accepted pixels; the extra MSB marks a full line.
  logic [IDX_W:0]   idx_q, idx_d;
  logic             ovf_q, ovf_d;

  logic             s1_vld_q, s1_vld_d;
  logic [PIX_W-1:0] s1_w_q, s1_w_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic             s1_hit_q, s1_hit_d;

  logic [NUM_W-1:0] numer_acc_q, numer_acc_d;
  logic [DEN_W-1:0] denom_acc_q, denom_acc_d;
  logic [IDX_W:0]   hits_acc_q, hits_acc_d;

  logic [NUM_W-1:0] numer_q, numer_d;
  logic [DEN_W-1:0] denom_q, denom_d;
  logic [IDX_W:0]   hits_q, hits_d;
  logic             line_valid_q, line_valid_d;
  logic             ovf_err_q, ovf_err_d;
  logic             flag_q, flag_d;

  logic             pix_take_s;
  logic             pix_accept_s;
  logic [PIX_W-1:0] w_s;
  logic [PROD_W-1:0] prod_s;
  logic             accept_s;

  // A pixel in the line_start_i cycle belongs to no line: index 0 is the next one.
  assign pix_take_s   = (state_q == S_ACCUM) && pix_valid_i && !line_start_i;
  assign pix_accept_s = pix_take_s && !idx_q[IDX_W];
  assign w_s          = (pix_data_i > thr_q) ? (pix_data_i - thr_q) : {PIX_W{1'b0}};
  assign prod_s       = {{IDX_W{1'b0}}, s1_w_q} * {{PIX_W{1'b0}}, s1_idx_q};
  assign accept_s     = !ovf_q && (hits_acc_q >= MIN_HITS) && (denom_acc_q != {DEN_W{1'b0}});

  // Next-state logic; line_start_i restarts a line from any state.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (line_start_i) begin
      state_d     = S_ACCUM;
      drain_cnt_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ACCUM: begin
          if (line_end_i) begin
            state_d     = S_DRAIN;
            drain_cnt_d = 1'b0;
          end else begin
            state_d = S_ACCUM;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q) begin
            state_d = S_DONE;
          end else begin
            drain_cnt_d = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Threshold capture, index/overflow tracking, pipeline stage 1 and stage 2.
  always_comb begin
    thr_d       = thr_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    s1_vld_d    = pix_accept_s;
    s1_w_d      = w_s;
    s1_idx_d    = idx_q[IDX_W-1:0];
    s1_hit_d    = (w_s != {PIX_W{1'b0}});
    numer_acc_d = numer_acc_q;
    denom_acc_d = denom_acc_q;
    hits_acc_d  = hits_acc_q;
    if (line_start_i) begin
      thr_d       = threshold_i;
      idx_d       = {(IDX_W+1){1'b0}};
      ovf_d       = 1'b0;
      numer_acc_d = {NUM_W{1'b0}};
      denom_acc_d = {DEN_W{1'b0}};
      hits_acc_d  = {(IDX_W+1){1'b0}};
    end else begin
      if (pix_accept_s) begin
        idx_d = idx_q + {{IDX_W{1'b0}}, 1'b1};
      end else if (pix_take_s) begin
        // Line already holds 2**IDX_W pixels: drop this one and flag it.
        ovf_d = 1'b1;
      end else begin
        idx_d = idx_q;
      end
      // Stage 2 still runs during DRAIN so the last pixel lands before DONE.
      if (s1_vld_q) begin
        numer_acc_d = numer_acc_q + {{(NUM_W-PROD_W){1'b0}}, prod_s};
        denom_acc_d = denom_acc_q + {{(DEN_W-PIX_W){1'b0}}, s1_w_q};
        hits_acc_d  = hits_acc_q + {{IDX_W{1'b0}}, s1_hit_q};
      end else begin
        numer_acc_d = numer_acc_q;
      end
    end
  end

  // Result latch: outputs load while leaving DONE and hold until the next DONE.
  always_comb begin
    numer_d      = numer_q;
    denom_d      = denom_q;
    hits_d       = hits_q;
    line_valid_d = line_valid_q;
    ovf_err_d    = ovf_err_q;
    flag_d       = 1'b0;
    if (state_q == S_DONE) begin
      flag_d       = 1'b1;
      hits_d       = hits_acc_q;
      ovf_err_d    = ovf_q;
      line_valid_d = accept_s;
      if (accept_s) begin
        numer_d = numer_acc_q;
        denom_d = denom_acc_q;
      end else begin
        numer_d = {NUM_W{1'b0}};
        denom_d = {DEN_W{1'b0}};
      end
    end else begin
      flag_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_200MHz_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Datapath registers: threshold, index, pipeline and accumulators.
  always_ff @(posedge clk_200MHz_i) begin
    if (!rst_n_i) begin
      thr_q       <= {PIX_W{1'b0}};
      idx_q       <= {(IDX_W+1){1'b0}};
      ovf_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_w_q      <= {PIX_W{1'b0}};
      s1_idx_q    <= {IDX_W{1'b0}};
      s1_hit_q    <= 1'b0;
      numer_acc_q <= {NUM_W{1'b0}};
      denom_acc_q <= {DEN_W{1'b0}};
      hits_acc_q  <= {(IDX_W+1){1'b0}};
    end else begin
      thr_q       <= thr_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      s1_vld_q    <= s1_vld_d;
      s1_w_q      <= s1_w_d;
      s1_idx_q    <= s1_idx_d;
      s1_hit_q    <= s1_hit_d;
      numer_acc_q <= numer_acc_d;
      denom_acc_q <= denom_acc_d;
      hits_acc_q  <= hits_acc_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk_200MHz_i) begin
    if (!rst_n_i) begin
      numer_q      <= {NUM_W{1'b0}};
      denom_q      <= {DEN_W{1'b0}};
      hits_q       <= {(IDX_W+1){1'b0}};
      line_valid_q <= 1'b0;
      ovf_err_q    <= 1'b0;
      flag_q       <= 1'b0;
    end else begin
      numer_q      <= numer_d;
      denom_q      <= denom_d;
      hits_q       <= hits_d;
      line_valid_q <= line_valid_d;
      ovf_err_q    <= ovf_err_d;
      flag_q       <= flag_d;
    end
  end

  assign numer_o         = numer_q;
  assign denom_o         = denom_q;
  assign hits_o          = hits_q;
  assign line_valid_o    = line_valid_q;
  assign ovf_err_o       = ovf_err_q;
  assign centroid_flag_o = flag_q;

endmodule

// File: tb/tb_line_centroid_accum.sv
// Testbench for line_centroid_accum. Two instances share all inputs: one with
// default widths and one with IDX_W=4 so that 16-pixel lines exercise the
// index overflow. Each scenario builds a per-cycle stimulus schedule, plays
// it, and compares the recorded outputs with a line-level reference model.
module tb_line_centroid_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic        line_end;
  logic        pix_valid;
  logic [11:0] pix_data;
  logic [11:0] threshold;

  logic [33:0] a_numer;
  logic [22:0] a_denom;
  logic [11:0] a_hits;
  logic        a_valid, a_ovf, a_flag;
  logic [19:0] b_numer;
  logic [15:0] b_denom;
  logic [4:0]  b_hits;
  logic        b_valid, b_ovf, b_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_centroid_accum dut_a (
    .clk_200MHz_i    (clk),
    .rst_n_i         (rst_n),
    .line_start_i    (line_start),
    .line_end_i      (line_end),
    .pix_valid_i     (pix_valid),
    .pix_data_i      (pix_data),
    .threshold_i     (threshold),
    .numer_o         (a_numer),
    .denom_o         (a_denom),
    .hits_o          (a_hits),
    .line_valid_o    (a_valid),
    .ovf_err_o       (a_ovf),
    .centroid_flag_o (a_flag)
  );

  line_centroid_accum #(.PIX_W(12), .IDX_W(4), .DEN_W(16), .NUM_W(20), .MIN_PIX(3)) dut_b (
    .clk_200MHz_i    (clk),
    .rst_n_i         (rst_n),
    .line_start_i    (line_start),
    .line_end_i      (line_end),
    .pix_valid_i     (pix_valid),
    .pix_data_i      (pix_data),
    .threshold_i     (threshold),
    .numer_o         (b_numer),
    .denom_o         (b_denom),
    .hits_o          (b_hits),
    .line_valid_o    (b_valid),
    .ovf_err_o       (b_ovf),
    .centroid_flag_o (b_flag)
  );

  typedef struct packed {
    logic        rst_n;
    logic        start;
    logic        endl;
    logic        valid;
    logic [11:0] data;
    logic [11:0] thr;
  } stim_t;

  typedef struct packed {
    logic [33:0] numer;
    logic [22:0] denom;
    logic [11:0] hits;
    logic        valid;
    logic        ovf;
    logic        flag;
  } obs_a_t;

  typedef struct packed {
    logic [19:0] numer;
    logic [15:0] denom;
    logic [4:0]  hits;
    logic        valid;
    logic        ovf;
    logic        flag;
  } obs_b_t;

  typedef struct packed {
    logic [63:0] numer;
    logic [63:0] denom;
    logic [31:0] hits;
    logic        valid;
    logic        ovf;
  } res_t;

  stim_t  sched[$];
  obs_a_t oa[$];
  obs_b_t ob[$];

  // Reference: whole-line result from the pixel list, threshold and index width.
  function automatic res_t model(input int unsigned pix[$], input int unsigned thr, input int idx_w);
    res_t r;
    int unsigned lim;
    int unsigned w;
    r = '0;
    lim = 32'd1 << idx_w;
    foreach (pix[i]) begin
      if (i >= lim) begin
        r.ovf = 1'b1;
      end else begin
        w = (pix[i] > thr) ? pix[i] - thr : 0;
        r.numer = r.numer + 64'(i) * 64'(w);
        r.denom = r.denom + 64'(w);
        if (w != 0) r.hits = r.hits + 32'd1;
      end
    end
    r.valid = !r.ovf && (r.hits >= 32'd3) && (r.denom != 64'd0);
    if (!r.valid) begin
      r.numer = 64'd0;
      r.denom = 64'd0;
    end
    return r;
  endfunction

  function automatic obs_a_t to_a(input res_t r);
    return {r.numer[33:0], r.denom[22:0], r.hits[11:0], r.valid, r.ovf, 1'b1};
  endfunction

  function automatic obs_b_t to_b(input res_t r);
    return {r.numer[19:0], r.denom[15:0], r.hits[4:0], r.valid, r.ovf, 1'b1};
  endfunction

  // Append one cycle of stimulus; threshold is random except on line_start.
  function automatic void add(input int r, input int s, input int e, input int v,
                              input int unsigned d, input int unsigned t);
    stim_t st;
    st.rst_n = (r != 0);
    st.start = (s != 0);
    st.endl  = (e != 0);
    st.valid = (v != 0);
    st.data  = d[11:0];
    st.thr   = (s != 0) ? t[11:0] : 12'($urandom_range(4095, 0));
    sched.push_back(st);
  endfunction

  // Idle cycles with random (to be ignored) pixel strobes.
  function automatic void pad(input int n, input int noisy);
    for (int k = 0; k < n; k++) add(1, 0, 0, noisy, $urandom_range(4095, 0), 0);
  endfunction

  // Append a line: start cycle, pixels with optional gaps, end on the last pixel.
  function automatic int add_line(input int unsigned pix[$], input int unsigned thr,
                                  input int gap_max, input int with_end);
    int g;
    add(1, 1, 0, 0, 0, thr);
    if (pix.size() == 0) begin
      add(1, 0, with_end, 0, 0, 0);
    end else begin
      foreach (pix[i]) begin
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int k = 0; k < g; k++) add(1, 0, 0, 0, $urandom_range(4095, 0), 0);
        add(1, 0, ((i == pix.size() - 1) && (with_end != 0)) ? 1 : 0, 1, pix[i], 0);
      end
    end
    return sched.size() - 1;
  endfunction

  // Drive the schedule; record outputs 1 time unit after each rising edge.
  task automatic play();
    oa.delete();
    ob.delete();
    foreach (sched[i]) begin
      rst_n      = sched[i].rst_n;
      line_start = sched[i].start;
      line_end   = sched[i].endl;
      pix_valid  = sched[i].valid;
      pix_data   = sched[i].data;
      threshold  = sched[i].thr;
      @(posedge clk);
      #1;
      oa.push_back({a_numer, a_denom, a_hits, a_valid, a_ovf, a_flag});
      ob.push_back({b_numer, b_denom, b_hits, b_valid, b_ovf, b_flag});
    end
    sched.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0);
    pad(5, 1);
    play();
    foreach (oa[i]) begin
      checks++;
      if (oa[i] !== '0 || ob[i] !== '0) begin
        errors++;
        $display("FAIL reset_state cyc %0d got a=%h b=%h exp 0", i, oa[i], ob[i]);
      end
    end
  endtask

  task automatic test_basic();
    int unsigned pix[$];
    int e;
    for (int i = 0; i < 16; i++) pix.push_back(50);
    pix[10] = 200;
    pix[11] = 300;
    pix[12] = 200;
    e = add_line(pix, 100, 0, 1);
    pad(6, 1);
    play();
    foreach (oa[i]) begin
      checks++;
      if ({oa[i].flag, ob[i].flag} !== {2{i == e + 3}}) begin
        errors++;
        $display("FAIL basic_flag cyc %0d got %b%b exp %0b", i, oa[i].flag, ob[i].flag, i == e + 3);
      end
    end
    checks++;
    if (oa[e+3] !== {34'd4400, 23'd400, 12'd3, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_rec_a got numer=%0d denom=%0d hits=%0d valid=%b ovf=%b exp 4400 400 3 1 0",
               oa[e+3].numer, oa[e+3].denom, oa[e+3].hits, oa[e+3].valid, oa[e+3].ovf);
    end
    checks++;
    if (ob[e+3] !== {20'd4400, 16'd400, 5'd3, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_rec_b_16pix got %h exp numer 4400 denom 400 hits 3 valid 1 ovf 0", ob[e+3]);
    end
    checks++;
    if (oa[oa.size()-1] !== {34'd4400, 23'd400, 12'd3, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_hold got %h exp numer 4400 denom 400 hits 3 valid 1 flag 0", oa[oa.size()-1]);
    end
  endtask

  task automatic test_reject();
    int unsigned pix[$];
    int e;
    for (int i = 0; i < 9; i++) pix.push_back(50);
    pix[5] = 180;
    e = add_line(pix, 100, 2, 1);
    pad(6, 1);
    play();
    foreach (oa[i]) begin
      checks++;
      if ({oa[i].flag, ob[i].flag} !== {2{i == e + 3}}) begin
        errors++;
        $display("FAIL reject_flag cyc %0d got %b%b exp %0b", i, oa[i].flag, ob[i].flag, i == e + 3);
      end
    end
    checks++;
    if (oa[e+3] !== {34'd0, 23'd0, 12'd1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reject_rec got numer=%0d denom=%0d hits=%0d valid=%b exp 0 0 1 0",
               oa[e+3].numer, oa[e+3].denom, oa[e+3].hits, oa[e+3].valid);
    end
  endtask

  task automatic test_abort();
    int unsigned pa[$];
    int unsigned pb[$];
    int unsigned pc[$];
    int unsigned pd[$];
    int unsigned thr_d;
    int e2, ec, ed;
    obs_a_t exd;
    for (int i = 0; i < 8; i++) pa.push_back($urandom_range(4095, 0));
    pb = '{1, 1, 2};
    for (int i = 0; i < 6; i++) pc.push_back($urandom_range(4095, 0));
    for (int i = 0; i < 10; i++) pd.push_back($urandom_range(1500, 0));
    thr_d = $urandom_range(600, 0);
    void'(add_line(pa, $urandom_range(100, 0), 0, 0));
    e2 = add_line(pb, 0, 0, 1);
    pad(5, 1);
    // Line C closes, then a new start lands in the last DRAIN cycle.
    ec = add_line(pc, 0, 0, 1);
    pad(1, 1);
    ed = add_line(pd, thr_d, 1, 1);
    pad(6, 1);
    exd = to_a(model(pd, thr_d, 11));
    play();
    foreach (oa[i]) begin
      checks++;
      if (oa[i].flag !== ((i == e2 + 3) || (i == ed + 3))) begin
        errors++;
        $display("FAIL abort_flag cyc %0d got %b exp %0b", i, oa[i].flag, (i == e2 + 3) || (i == ed + 3));
      end
    end
    checks++;
    if (oa[e2+3] !== {34'd5, 23'd4, 12'd3, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort_rec got numer=%0d denom=%0d hits=%0d valid=%b exp 5 4 3 1",
               oa[e2+3].numer, oa[e2+3].denom, oa[e2+3].hits, oa[e2+3].valid);
    end
    checks++;
    if (oa[ed+3] !== exd) begin
      errors++;
      $display("FAIL abort_drain_rec (C end %0d) got %h exp %h", ec, oa[ed+3], exd);
    end
  endtask

  task automatic test_overflow();
    int unsigned p1[$];
    int unsigned p2[$];
    int e1, e2;
    obs_b_t exb;
    for (int i = 0; i < 20; i++) p1.push_back(10);
    p2 = '{5, 7, 9, 3};
    e1 = add_line(p1, 0, 0, 1);
    pad(6, 1);
    e2 = add_line(p2, 2, 1, 1);
    pad(6, 1);
    exb = to_b(model(p2, 2, 4));
    play();
    checks++;
    if ({ob[e1+3].ovf, ob[e1+3].valid, ob[e1+3].flag} !== 3'b101) begin
      errors++;
      $display("FAIL ovf_set got ovf=%b valid=%b flag=%b exp 1 0 1", ob[e1+3].ovf, ob[e1+3].valid, ob[e1+3].flag);
    end
    checks++;
    if (oa[e1+3] !== {34'd1900, 23'd200, 12'd20, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_wide_rec got %h exp numer 1900 denom 200 hits 20 valid 1", oa[e1+3]);
    end
    checks++;
    if (ob[e2+3] !== exb) begin
      errors++;
      $display("FAIL ovf_clear got %h exp %h", ob[e2+3], exb);
    end
    foreach (ob[i]) begin
      checks++;
      if (ob[i].flag !== ((i == e1 + 3) || (i == e2 + 3))) begin
        errors++;
        $display("FAIL ovf_flag cyc %0d got %b", i, ob[i].flag);
      end
    end
  endtask

  task automatic test_reset_midline();
    int r;
    add(1, 1, 0, 0, 0, 20);
    pad(5, 1);
    r = sched.size();
    add(0, 0, 0, 1, 500, 0);
    pad(3, 1);
    add(1, 0, 1, 1, 600, 0);
    pad(6, 1);
    play();
    for (int i = r; i < oa.size(); i++) begin
      checks++;
      if (oa[i] !== '0 || ob[i] !== '0) begin
        errors++;
        $display("FAIL reset_midline cyc %0d got a=%h b=%h exp 0", i, oa[i], ob[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned p1[$];
    int unsigned p2[$];
    int unsigned t1, t2;
    int e1, e2;
    stim_t st;
    obs_a_t x1, x2;
    obs_b_t y1, y2;
    for (int i = 0; i < 12; i++) p1.push_back($urandom_range(3000, 0));
    for (int i = 0; i < 14; i++) p2.push_back($urandom_range(3000, 0));
    t1 = $urandom_range(800, 0);
    t2 = $urandom_range(800, 0);
    e1 = add_line(p1, t1, 0, 1);
    pad(2, 1);
    e2 = add_line(p2, t2, 0, 1);
    // Line 2 starts in the DONE cycle with the pixel strobe still high.
    st = sched[e1+3];
    st.valid = 1'b1;
    st.data  = 12'($urandom_range(4095, 0));
    sched[e1+3] = st;
    pad(3, 1);
    add(1, 0, 1, 0, 0, 0);
    pad(5, 1);
    x1 = to_a(model(p1, t1, 11));
    x2 = to_a(model(p2, t2, 11));
    y1 = to_b(model(p1, t1, 4));
    y2 = to_b(model(p2, t2, 4));
    play();
    foreach (oa[i]) begin
      checks++;
      if ({oa[i].flag, ob[i].flag} !== {2{(i == e1 + 3) || (i == e2 + 3)}}) begin
        errors++;
        $display("FAIL b2b_flag cyc %0d got %b%b", i, oa[i].flag, ob[i].flag);
      end
    end
    checks++;
    if (oa[e1+3] !== x1 || ob[e1+3] !== y1) begin
      errors++;
      $display("FAIL b2b_rec1 got a=%h b=%h exp a=%h b=%h", oa[e1+3], ob[e1+3], x1, y1);
    end
    checks++;
    if (oa[e2+3] !== x2 || ob[e2+3] !== y2) begin
      errors++;
      $display("FAIL b2b_rec2 got a=%h b=%h exp a=%h b=%h", oa[e2+3], ob[e2+3], x2, y2);
    end
  endtask

  task automatic test_random();
    int unsigned pix[$];
    int unsigned thr;
    int e, n, g;
    int ends[$];
    obs_a_t xa[$];
    obs_b_t xb[$];
    bit ef[];
    pad(2, 1);
    for (int l = 0; l < 10; l++) begin
      pix.delete();
      n = $urandom_range(24, 0);
      for (int k = 0; k < n; k++) pix.push_back($urandom_range(4095, 0));
      thr = $urandom_range(2000, 0);
      e = add_line(pix, thr, 2, 1);
      ends.push_back(e);
      xa.push_back(to_a(model(pix, thr, 11)));
      xb.push_back(to_b(model(pix, thr, 4)));
      g = $urandom_range(5, 2);
      pad(g, 1);
    end
    pad(6, 1);
    play();
    ef = new[oa.size()];
    foreach (ends[j]) ef[ends[j] + 3] = 1'b1;
    foreach (oa[i]) begin
      checks++;
      if ({oa[i].flag, ob[i].flag} !== {2{ef[i]}}) begin
        errors++;
        $display("FAIL rand_flag cyc %0d got %b%b exp %0b", i, oa[i].flag, ob[i].flag, ef[i]);
      end
    end
    foreach (ends[j]) begin
      checks++;
      if (oa[ends[j]+3] !== xa[j] || ob[ends[j]+3] !== xb[j]) begin
        errors++;
        $display("FAIL rand_rec line %0d got a=%h b=%h exp a=%h b=%h",
                 j, oa[ends[j]+3], ob[ends[j]+3], xa[j], xb[j]);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    line_start = 1'b0;
    line_end   = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = 12'd0;
    threshold  = 12'd0;
    test_reset();
    test_basic();
    test_reject();
    test_abort();
    test_overflow();
    test_reset_midline();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
